// File: rtl/lenet_fc_layer_pe.sv
// LANES-wide FC neuron PE: shared activation stream, per-lane weight RAM and bias, pipelined MAC -> bias -> requantise.
// Results follow the last beat by 3 flush + 1 bias + 1 quant cycles; they stream one lane per i_ready handshake and o_ready is low outside IDLE/ACC.
module lenet_fc_layer_pe #(
  parameter  int WD    = 4,
  parameter  int WW    = 8,
  parameter  int N_IN  = 128,
  parameter  int LANES = 4,
  parameter  int NW    = 8,
  parameter  int OW    = 8,
  parameter  int SHIFT = 0,
  parameter  int RELU  = 1,
  localparam int AW    = $clog2(N_IN),
  localparam int LB    = $clog2(LANES)
) (
  input  logic                 i_sclk,
  input  logic                 i_rstn,
  input  logic [NW-LB-1:0]     i_channel,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [WD-1:0]        i_tdata,
  input  logic                 i_last,
  input  logic                 i_W_en,
  input  logic [NW-1:0]        i_W_num,
  input  logic [AW-1:0]        i_W_addr,
  input  logic signed [WW-1:0] i_Weight,
  input  logic                 i_B_en,
  input  logic [NW-1:0]        i_B_num,
  input  logic signed [WW-1:0] i_Bias,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [LB-1:0]        o_lane,
  output logic [OW-1:0]        o_tdata,
  output logic                 o_last,
  output logic                 o_busy,
  output logic                 o_err
);

  localparam int PW    = WW + WD + 1;
  localparam int ACC_W = PW + AW + 1;
  localparam logic signed [ACC_W-1:0] QMAX = ACC_W'((2 ** (OW - 1)) - 1);
  localparam logic signed [ACC_W-1:0] QMIN = ACC_W'(-(2 ** (OW - 1)));

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ACC   = 3'd1;
  localparam logic [2:0] S_FLUSH = 3'd2;
  localparam logic [2:0] S_BIAS  = 3'd3;
  localparam logic [2:0] S_QUANT = 3'd4;
  localparam logic [2:0] S_OUT   = 3'd5;

  logic [2:0]              state;
  logic [AW-1:0]           cnt;
  logic [1:0]              flush_cnt;
  logic [LB-1:0]           lane;
  logic                    err;

  logic signed [WW-1:0]    wram  [LANES][N_IN];
  logic signed [WW-1:0]    bias  [LANES];
  logic signed [WW-1:0]    rd_w  [LANES];
  logic signed [PW-1:0]    prod  [LANES];
  logic signed [ACC_W-1:0] acc   [LANES];
  logic signed [ACC_W-1:0] shr   [LANES];
  logic signed [OW-1:0]    q     [LANES];
  logic signed [OW-1:0]    res   [LANES];

  logic [WD-1:0]           act_d1;
  logic                    vld_d1;
  logic                    vld_d2;

  logic                    wr_vld;
  logic [LB-1:0]           wr_lane;
  logic [AW-1:0]           wr_addr;
  logic signed [WW-1:0]    wr_dat;

  logic busy;
  logic beat;
  logic at_max;
  logic last_beat;
  logic forced;
  logic w_hit;
  logic b_hit;
  logic out_done;

  assign busy      = (state != S_IDLE);
  assign o_ready   = (state == S_IDLE) || (state == S_ACC);
  assign beat      = i_valid && o_ready;
  assign at_max    = (cnt == AW'(N_IN - 1));
  assign last_beat = beat && (i_last || at_max);
  assign forced    = beat && !i_last && at_max;
  assign w_hit     = i_W_en && (i_W_num[NW-1:LB] == i_channel);
  assign b_hit     = i_B_en && (i_B_num[NW-1:LB] == i_channel);
  assign out_done  = (state == S_OUT) && i_ready && (lane == LB'(LANES - 1));

  assign o_valid = (state == S_OUT);
  assign o_lane  = o_valid ? lane : '0;
  assign o_tdata = o_valid ? res[lane] : '0;
  assign o_last  = o_valid && (lane == LB'(LANES - 1));
  assign o_busy  = busy;
  assign o_err   = err;

  // Weight RAM and the multiply stage carry no reset; only their valids do.
  always_ff @(posedge i_sclk) begin
    if (wr_vld) wram[wr_lane][wr_addr] <= wr_dat;
    for (int l = 0; l < LANES; l++) begin
      rd_w[l] <= wram[l][cnt];
      prod[l] <= PW'(rd_w[l]) * PW'($signed({1'b0, act_d1}));
    end
  end

  always_ff @(posedge i_sclk) begin
    if (!i_rstn) begin
      wr_vld <= 1'b0;
      for (int l = 0; l < LANES; l++) bias[l] <= '0;
    end else begin
      wr_vld <= w_hit && !busy;
      if (w_hit) begin
        wr_lane <= i_W_num[LB-1:0];
        wr_addr <= i_W_addr;
        wr_dat  <= i_Weight;
      end
      if (b_hit && !busy) bias[i_B_num[LB-1:0]] <= i_Bias;
    end
  end

  always_ff @(posedge i_sclk) begin
    if (!i_rstn) begin
      vld_d1 <= 1'b0;
      vld_d2 <= 1'b0;
      act_d1 <= '0;
    end else begin
      vld_d1 <= beat;
      vld_d2 <= vld_d1;
      if (beat) act_d1 <= i_tdata;
    end
  end

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      shr[l] = acc[l] >>> SHIFT;
      if ((RELU != 0) && (shr[l] < 0)) shr[l] = '0;
      if (shr[l] > QMAX)      q[l] = QMAX[OW-1:0];
      else if (shr[l] < QMIN) q[l] = QMIN[OW-1:0];
      else                    q[l] = shr[l][OW-1:0];
    end
  end

  always_ff @(posedge i_sclk) begin
    if (!i_rstn) begin
      state     <= S_IDLE;
      cnt       <= '0;
      flush_cnt <= '0;
      lane      <= '0;
      err       <= 1'b0;
      for (int l = 0; l < LANES; l++) begin
        acc[l] <= '0;
        res[l] <= '0;
      end
    end else begin
      err <= forced || (busy && (w_hit || b_hit));
      for (int l = 0; l < LANES; l++) begin
        if (out_done)               acc[l] <= '0;
        else if (state == S_BIAS)   acc[l] <= acc[l] + ACC_W'(bias[l]);
        else if (vld_d2)            acc[l] <= acc[l] + ACC_W'(prod[l]);
      end
      case (state)
        S_IDLE, S_ACC: begin
          if (beat) begin
            cnt   <= cnt + AW'(1);
            state <= last_beat ? S_FLUSH : S_ACC;
          end
        end
        // Three cycles cover RAM read, product register and the final accumulate.
        S_FLUSH: begin
          flush_cnt <= flush_cnt + 2'd1;
          if (flush_cnt == 2'd2) begin
            flush_cnt <= '0;
            state     <= S_BIAS;
          end
        end
        S_BIAS: state <= S_QUANT;
        S_QUANT: begin
          for (int l = 0; l < LANES; l++) res[l] <= q[l];
          lane  <= '0;
          state <= S_OUT;
        end
        S_OUT: begin
          if (i_ready) begin
            if (lane == LB'(LANES - 1)) begin
              lane  <= '0;
              cnt   <= '0;
              state <= S_IDLE;
            end else begin
              lane <= lane + LB'(1);
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lenet_fc_layer_pe.sv
// Bench: three PE instances (plain, ReLU, shift-by-4) share one stimulus stream and are checked against an arithmetic model.
module tb_lenet_fc_layer_pe;
  localparam int WD = 4, WW = 8, N_IN = 4, LANES = 2, NW = 8, OW = 8;
  localparam int LB = 1, AW = 2, NI = 3;

  logic                 i_sclk = 1'b0;
  logic                 i_rstn;
  logic [NW-LB-1:0]     i_channel;
  logic                 i_valid, i_last, i_ready;
  logic [WD-1:0]        i_tdata;
  logic                 i_W_en, i_B_en;
  logic [NW-1:0]        i_W_num, i_B_num;
  logic [AW-1:0]        i_W_addr;
  logic [WW-1:0]        i_Weight, i_Bias;
  logic [NI-1:0]        o_ready_v, o_valid_v, o_last_v, o_busy_v, o_err_v;
  logic [LB-1:0]        o_lane_v  [NI];
  logic [OW-1:0]        o_tdata_v [NI];

  int checks = 0;
  int errors = 0;
  int chan   = 0;
  int wm [LANES][N_IN];
  int bm [LANES];
  int xs [N_IN];
  int exp_q [NI][LANES];

  always #5 i_sclk = ~i_sclk;

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    lenet_fc_layer_pe #(
      .WD(WD), .WW(WW), .N_IN(N_IN), .LANES(LANES), .NW(NW), .OW(OW),
      .SHIFT((gi == 2) ? 4 : 0), .RELU((gi == 1) ? 1 : 0)
    ) u_dut (
      .i_sclk(i_sclk), .i_rstn(i_rstn), .i_channel(i_channel),
      .i_valid(i_valid), .o_ready(o_ready_v[gi]), .i_tdata(i_tdata), .i_last(i_last),
      .i_W_en(i_W_en), .i_W_num(i_W_num), .i_W_addr(i_W_addr), .i_Weight(i_Weight),
      .i_B_en(i_B_en), .i_B_num(i_B_num), .i_Bias(i_Bias),
      .o_valid(o_valid_v[gi]), .i_ready(i_ready), .o_lane(o_lane_v[gi]),
      .o_tdata(o_tdata_v[gi]), .o_last(o_last_v[gi]), .o_busy(o_busy_v[gi]), .o_err(o_err_v[gi])
    );
  end

  function automatic int quant(input int acc, input int sh, input int relu);
    int r;
    r = acc >>> sh;
    if (relu != 0 && r < 0) r = 0;
    if (r > 127) r = 127;
    if (r < -128) r = -128;
    return r;
  endfunction

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wr_w(input int num, input int addr, input int val);
    @(negedge i_sclk);
    i_W_en = 1'b1; i_W_num = NW'(num); i_W_addr = AW'(addr); i_Weight = WW'(val);
    if ((num / LANES) == chan) wm[num % LANES][addr] = val;
    @(negedge i_sclk);
    i_W_en = 1'b0;
    chk("idle_wr_err", o_err_v[0], 0);
  endtask

  task automatic wr_b(input int num, input int val);
    @(negedge i_sclk);
    i_B_en = 1'b1; i_B_num = NW'(num); i_Bias = WW'(val);
    if ((num / LANES) == chan) bm[num % LANES] = val;
    @(negedge i_sclk);
    i_B_en = 1'b0;
  endtask

  task automatic load_lane(input int l, input int a, input int b, input int c, input int d);
    wr_w(chan * LANES + l, 0, a);
    wr_w(chan * LANES + l, 1, b);
    wr_w(chan * LANES + l, 2, c);
    wr_w(chan * LANES + l, 3, d);
  endtask

  task automatic feed(input int n, input bit use_last, input bit busy_wr);
    bit err_exp = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(negedge i_sclk);
      chk("beat_ready", o_ready_v[0], 1);
      chk("beat_err", o_err_v[0], err_exp);
      i_valid = 1'b1;
      i_tdata = WD'(xs[k]);
      i_last  = use_last && (k == n - 1);
      i_W_en  = busy_wr && (k == 1);
      i_W_num = NW'(chan * LANES); i_W_addr = '0; i_Weight = 8'h55;
      err_exp = (busy_wr && k == 1) || (!use_last && k == N_IN - 1);
    end
    @(negedge i_sclk);
    i_valid = 1'b0; i_last = 1'b0; i_W_en = 1'b0;
    chk("end_err", o_err_v[0], err_exp);
    chk("end_ready", o_ready_v[0], 0);
    chk("end_busy", o_busy_v[0], 1);
  endtask

  task automatic collect(input int stall);
    int lane = 0;
    int guard = 0;
    int stalls = 0;
    while (lane < LANES && guard < 100) begin
      @(negedge i_sclk);
      guard++;
      i_valid = 1'b0;
      if (o_valid_v[0]) begin
        chk("out_lane", o_lane_v[0], lane);
        chk("out_last", o_last_v[0], lane == LANES - 1);
        for (int i = 0; i < NI; i++)
          chk($sformatf("out_data_inst%0d_lane%0d", i, lane), $signed(o_tdata_v[i]), exp_q[i][lane]);
        if (stalls < stall) begin
          stalls++;
          chk("stall_ready", o_ready_v[0], 0);
          i_ready = 1'b0; i_valid = 1'b1;
          i_tdata = WD'($urandom); i_last = 1'($urandom);
        end else begin
          i_ready = ($urandom_range(0, 3) != 0);
          if (i_ready) lane++;
        end
      end else begin
        i_ready = 1'b0;
      end
    end
    if (lane < LANES) chk("out_timeout", lane, LANES);
    @(negedge i_sclk);
    i_ready = 1'b0; i_valid = 1'b0; i_last = 1'b0;
    chk("post_valid", o_valid_v[0], 0);
    chk("post_busy", o_busy_v[0], 0);
    chk("post_ready", o_ready_v[0], 1);
  endtask

  task automatic run(input int n, input bit use_last, input bit busy_wr, input int stall);
    for (int i = 0; i < NI; i++)
      for (int l = 0; l < LANES; l++) begin
        int acc = bm[l];
        for (int k = 0; k < n; k++) acc += wm[l][k] * xs[k];
        exp_q[i][l] = quant(acc, (i == 2) ? 4 : 0, (i == 1) ? 1 : 0);
      end
    feed(n, use_last, busy_wr);
    collect(stall);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_ready", o_ready_v[0], 1);
    chk("rst_valid", o_valid_v[0], 0);
    chk("rst_busy", o_busy_v[0], 0);
    chk("rst_err", o_err_v[0], 0);
    chk("rst_last", o_last_v[0], 0);
    chk("rst_lane", o_lane_v[0], 0);
    chk("rst_data", o_tdata_v[0], 0);
  endtask

  initial begin
    i_rstn = 1'b0; i_channel = '0; i_valid = 1'b0; i_last = 1'b0; i_ready = 1'b0;
    i_tdata = '0; i_W_en = 1'b0; i_W_num = '0; i_W_addr = '0; i_Weight = '0;
    i_B_en = 1'b0; i_B_num = '0; i_Bias = '0;
    for (int l = 0; l < LANES; l++) bm[l] = 0;
    repeat (3) @(negedge i_sclk);
    chk_reset_outputs();
    i_rstn = 1'b1;

    // Reference frame: 56 / -18 (ReLU 56 / 0, shift-4 3 / -2).
    load_lane(0, 1, 2, 3, 4);
    load_lane(1, -1, -1, -1, -1);
    wr_b(0, 5); wr_b(1, 0);
    xs = '{2, 0, 15, 1};
    run(4, 1'b1, 1'b0, 0);
    run(4, 1'b1, 1'b0, 5);

    // Saturation at both ends, then shift-by-4 of 60.
    load_lane(0, 127, 127, 127, 127);
    load_lane(1, -128, -128, -128, -128);
    wr_b(0, 0);
    xs = '{15, 15, 15, 15};
    run(4, 1'b1, 1'b0, 0);
    load_lane(0, 1, 1, 1, 1);
    run(4, 1'b1, 1'b0, 0);

    // Forced end, busy-time write drop, single-beat frame.
    xs = '{7, 3, 12, 9};
    run(4, 1'b0, 1'b0, 0);
    run(3, 1'b1, 1'b1, 1);
    run(1, 1'b1, 1'b0, 0);

    // Channel 1 owns neurons 2..3; writes to neuron 0 are ignored.
    chan = 1; i_channel = NW'(1) >> 0;
    load_lane(0, 3, -2, 5, 1);
    load_lane(1, -7, 4, 0, 2);
    wr_w(0, 0, 99);
    wr_b(2, -7); wr_b(3, 11); wr_b(0, 100);
    xs = '{4, 9, 1, 14};
    run(4, 1'b1, 1'b0, 0);
    chan = 0; i_channel = '0;

    // Reset in mid-frame, then bias-cleared frame, then reference frame again.
    load_lane(0, 1, 2, 3, 4);
    load_lane(1, -1, -1, -1, -1);
    xs = '{2, 0, 15, 1};
    for (int k = 0; k < 2; k++) begin
      @(negedge i_sclk);
      i_valid = 1'b1; i_tdata = WD'(xs[k]); i_last = 1'b0;
    end
    @(negedge i_sclk);
    i_valid = 1'b0; i_rstn = 1'b0;
    @(negedge i_sclk);
    chk_reset_outputs();
    i_rstn = 1'b1;
    for (int l = 0; l < LANES; l++) bm[l] = 0;
    run(4, 1'b1, 1'b0, 0);
    wr_b(0, 5); wr_b(1, 0);
    run(4, 1'b1, 1'b0, 0);

    // Randomised frames.
    for (int it = 0; it < 25; it++) begin
      int n;
      bit use_last;
      for (int l = 0; l < LANES; l++) begin
        for (int a = 0; a < N_IN; a++) begin
          int num = ($urandom_range(0, 3) == 0) ? (chan + 1 + int'($urandom_range(0, 4))) * LANES + l
                                                 : chan * LANES + l;
          wr_w(num, a, int'($urandom_range(0, 255)) - 128);
        end
        wr_b(chan * LANES + l, int'($urandom_range(0, 255)) - 128);
      end
      for (int k = 0; k < N_IN; k++) xs[k] = int'($urandom_range(0, 15));
      n = int'($urandom_range(1, N_IN));
      use_last = (n < N_IN) ? 1'b1 : 1'($urandom);
      run(n, use_last, (n >= 2) && ($urandom_range(0, 2) == 0), int'($urandom_range(0, 2)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
